// File: rtl/wght_spad_pingpong_pkg.sv
// Shared defaults and bank-state encoding for the ping-pong weight scratchpad.
package wght_spad_pingpong_pkg;

    localparam int unsigned DEF_DATA_BITWIDTH     = 16;
    localparam int unsigned DEF_ADDR_BITWIDTH_SPAD = 9;
    localparam int unsigned DEF_KERNEL_SIZE       = 3;
    localparam int unsigned DEF_WPF               = DEF_KERNEL_SIZE ** 2;

    // Per-bank lifecycle: filled by the router, drained by the MAC.
    typedef enum logic [1:0] {
        BankEmpty   = 2'b00,
        BankFilling = 2'b01,
        BankFull    = 2'b10
    } bank_state_e;

endpackage

// File: rtl/wght_spad_pingpong_regfile.sv
// Register file: one synchronous write port, one registered read port.
// Storage is not reset; only the read-data register is.
module spad_regfile_1r1w
    import wght_spad_pingpong_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_BITWIDTH,
    parameter int unsigned DEPTH = 2 * DEF_WPF,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port: storage contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port: holds its last value when no read is enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wght_spad_pingpong.sv
// Two-bank weight scratchpad: the router fills one bank while the MAC reads the other.
module wght_spad_pingpong
    import wght_spad_pingpong_pkg::*;
#(
    parameter int unsigned DATA_BITWIDTH      = DEF_DATA_BITWIDTH,
    parameter int unsigned ADDR_BITWIDTH_SPAD = DEF_ADDR_BITWIDTH_SPAD,
    parameter int unsigned kernel_size        = DEF_KERNEL_SIZE
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITWIDTH-1:0]      w_data_spad,
    input  logic                          load_en_spad,
    output logic                          wr_ready,
    output logic                          load_done,
    output logic                          rd_avail,
    input  logic                          r_req,
    input  logic [ADDR_BITWIDTH_SPAD-1:0] r_addr,
    output logic [DATA_BITWIDTH-1:0]      r_data,
    output logic                          r_valid,
    input  logic                          rd_release,
    output logic                          overflow_err
);

    localparam int unsigned WPF  = kernel_size ** 2;
    localparam int unsigned CntW = $clog2(WPF);
    localparam int unsigned AW   = $clog2(2 * WPF);

    bank_state_e     bank_state_q [2];
    logic            wr_bank_q;
    logic            rd_bank_q;
    logic [CntW-1:0] wr_cnt_q;
    logic            load_done_q;
    logic            r_valid_q;
    logic            overflow_err_q;

    logic [1:0]      full;
    logic            wr_fire;
    logic            wr_last;
    logic            rel_fire;
    logic            rd_fire;
    logic [AW-1:0]   rf_waddr;
    logic [AW-1:0]   rf_raddr;

    // Decode bank fullness and qualify the three event strobes.
    always_comb begin
        full[0]  = (bank_state_q[0] == BankFull);
        full[1]  = (bank_state_q[1] == BankFull);
        wr_ready = ~full[wr_bank_q];
        rd_avail = full[rd_bank_q];
        wr_fire  = load_en_spad & wr_ready;
        wr_last  = wr_fire & (wr_cnt_q == CntW'(WPF - 1));
        rel_fire = rd_release & full[rd_bank_q];
        rd_fire  = r_req & rd_avail & (r_addr < ADDR_BITWIDTH_SPAD'(WPF));
        // Flat index = bank * WPF + idx.
        rf_waddr = wr_bank_q ? AW'(WPF) + AW'(wr_cnt_q) : AW'(wr_cnt_q);
        rf_raddr = rd_bank_q ? AW'(WPF) + AW'(r_addr) : AW'(r_addr);
    end

    // Bank state machines, bank pointers, fill counter and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_state_q[0] <= BankEmpty;
            bank_state_q[1] <= BankEmpty;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            wr_cnt_q        <= '0;
            load_done_q     <= 1'b0;
            r_valid_q       <= 1'b0;
            overflow_err_q  <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                case (bank_state_q[b])
                    BankEmpty: begin
                        if (wr_fire && wr_bank_q == 1'(b)) begin
                            bank_state_q[b] <= wr_last ? BankFull : BankFilling;
                        end
                    end
                    BankFilling: begin
                        if (wr_last && wr_bank_q == 1'(b)) begin
                            bank_state_q[b] <= BankFull;
                        end
                    end
                    BankFull: begin
                        if (rel_fire && rd_bank_q == 1'(b)) begin
                            bank_state_q[b] <= BankEmpty;
                        end
                    end
                    default: bank_state_q[b] <= BankEmpty;
                endcase
            end

            if (wr_last) begin
                wr_cnt_q  <= '0;
                wr_bank_q <= ~wr_bank_q;
            end else if (wr_fire) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end

            if (rel_fire) begin
                rd_bank_q <= ~rd_bank_q;
            end

            load_done_q <= wr_last;
            r_valid_q   <= rd_fire;
            // A strobe against a full bank is dropped and latched as an error.
            if (load_en_spad && !wr_ready) begin
                overflow_err_q <= 1'b1;
            end
        end
    end

    spad_regfile_1r1w #(
        .WIDTH (DATA_BITWIDTH),
        .DEPTH (2 * WPF)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (wr_fire),
        .waddr (rf_waddr),
        .wdata (w_data_spad),
        .re    (rd_fire),
        .raddr (rf_raddr),
        .rdata (r_data)
    );

    assign load_done    = load_done_q;
    assign r_valid      = r_valid_q;
    assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_wght_spad_pingpong.sv
// Scoreboard bench for wght_spad_pingpong: reads push expected data, a monitor pops on r_valid.
module tb_wght_spad_pingpong;

    logic        clk;
    logic        reset;
    logic [15:0] w_data_spad;
    logic        load_en_spad;
    logic        wr_ready;
    logic        load_done;
    logic        rd_avail;
    logic        r_req;
    logic [8:0]  r_addr;
    logic [15:0] r_data;
    logic        r_valid;
    logic        rd_release;
    logic        overflow_err;

    int tests_run;
    int tests_failed;
    logic [15:0] exp_q [$];

    wght_spad_pingpong dut (
        .clk          (clk),
        .reset        (reset),
        .w_data_spad  (w_data_spad),
        .load_en_spad (load_en_spad),
        .wr_ready     (wr_ready),
        .load_done    (load_done),
        .rd_avail     (rd_avail),
        .r_req        (r_req),
        .r_addr       (r_addr),
        .r_data       (r_data),
        .r_valid      (r_valid),
        .rd_release   (rd_release),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every r_valid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (reset && r_valid) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rd_unexpected: got r_valid=1 data %0h expected no read", r_data);
            end else begin
                chk("rd_data", {16'h0, r_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] v);
        load_en_spad = 1'b1;
        w_data_spad  = v;
        cyc();
        load_en_spad = 1'b0;
    endtask

    task automatic rd(input int a, input logic [15:0] exp, input bit valid);
        r_req  = 1'b1;
        r_addr = 9'(a);
        if (valid) exp_q.push_back(exp);
        cyc();
        r_req = 1'b0;
    endtask

    task automatic release_bank();
        rd_release = 1'b1;
        cyc();
        rd_release = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    // Write base+1..base+9 and check load_done pulses only after the 9th.
    task automatic fill(input string name, input int base);
        for (int i = 1; i <= 9; i++) begin
            wr(16'(base + i));
            if (i >= 8) chk({name, "_load_done"}, {31'h0, load_done}, {31'h0, i == 9});
        end
        cyc();
        chk({name, "_load_done_drop"}, {31'h0, load_done}, 32'h0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        w_data_spad  = '0;
        load_en_spad = 1'b0;
        r_req        = 1'b0;
        r_addr       = '0;
        rd_release   = 1'b0;
        #12;
        chk("rst_wr_ready", {31'h0, wr_ready}, 32'h1);
        chk("rst_rd_avail", {31'h0, rd_avail}, 32'h0);
        chk("rst_load_done", {31'h0, load_done}, 32'h0);
        chk("rst_r_valid", {31'h0, r_valid}, 32'h0);
        chk("rst_r_data", {16'h0, r_data}, 32'h0);
        chk("rst_overflow", {31'h0, overflow_err}, 32'h0);
        reset = 1'b1;
        cyc();

        // Basic load 1..9 into bank0, then read it back back-to-back.
        for (int i = 1; i <= 9; i++) begin
            chk("t1_wr_ready", {31'h0, wr_ready}, 32'h1);
            wr(16'(i));
            chk("t1_load_done", {31'h0, load_done}, {31'h0, i == 9});
        end
        chk("t1_rd_avail", {31'h0, rd_avail}, 32'h1);
        chk("t1_wr_ready_after", {31'h0, wr_ready}, 32'h1);
        for (int a = 0; a < 9; a++) rd(a, 16'(a + 1), 1'b1);
        cyc();

        // Both banks full, overflow, release, then refill the freed bank.
        fill("t2_b1", 10);
        chk("t2_wr_ready_full", {31'h0, wr_ready}, 32'h0);
        wr(16'd99);
        chk("t2_overflow", {31'h0, overflow_err}, 32'h1);
        chk("t2_no_done", {31'h0, load_done}, 32'h0);
        release_bank();
        chk("t2_wr_ready_rel", {31'h0, wr_ready}, 32'h1);
        chk("t2_rd_avail_rel", {31'h0, rd_avail}, 32'h1);
        rd(0, 16'd11, 1'b1);
        fill("t2_b0", 20);
        chk("t2_overflow_sticky", {31'h0, overflow_err}, 32'h1);
        release_bank();
        rd(0, 16'd21, 1'b1);
        rd(8, 16'd29, 1'b1);
        cyc();

        // Rejected reads: no bank available, then out-of-range address.
        do_reset();
        rd(0, 16'h0, 1'b0);
        chk("t3_noavail_valid", {31'h0, r_valid}, 32'h0);
        chk("t3_noavail_data", {16'h0, r_data}, 32'h0);
        fill("t3_b0", 0);
        rd(3, 16'd4, 1'b1);
        rd(9, 16'h0, 1'b0);
        chk("t3_addr9_valid", {31'h0, r_valid}, 32'h0);
        chk("t3_addr9_data", {16'h0, r_data}, 32'h4);
        rd(511, 16'h0, 1'b0);
        chk("t3_addr511_data", {16'h0, r_data}, 32'h4);

        // Fill completion on bank1, release of bank0 and a bank0 read, all in one cycle.
        for (int i = 1; i <= 8; i++) wr(16'(40 + i));
        load_en_spad = 1'b1;
        w_data_spad  = 16'd49;
        rd_release   = 1'b1;
        r_req        = 1'b1;
        r_addr       = 9'd2;
        exp_q.push_back(16'd3);
        cyc();
        load_en_spad = 1'b0;
        rd_release   = 1'b0;
        r_req        = 1'b0;
        chk("t4_load_done", {31'h0, load_done}, 32'h1);
        chk("t4_rd_avail", {31'h0, rd_avail}, 32'h1);
        chk("t4_wr_ready", {31'h0, wr_ready}, 32'h1);
        rd(0, 16'd41, 1'b1);
        rd(8, 16'd49, 1'b1);
        cyc();

        // Gapped load of -5..3 with load_en toggling every cycle.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            load_en_spad = (i % 2 == 0);
            w_data_spad  = 16'(i / 2 - 5);
            cyc();
            chk("t5_load_done", {31'h0, load_done}, {31'h0, i == 16});
        end
        load_en_spad = 1'b0;
        rd(0, 16'hFFFB, 1'b1);
        rd(4, 16'hFFFF, 1'b1);
        rd(5, 16'h0000, 1'b1);
        for (int a = 6; a < 9; a++) rd(a, 16'(a - 5), 1'b1);
        cyc();

        // Asynchronous reset in the middle of a partial fill.
        for (int i = 0; i < 4; i++) wr(16'(100 + i));
        chk("t6_pre_rd_avail", {31'h0, rd_avail}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rd_avail", {31'h0, rd_avail}, 32'h0);
        chk("t6_r_data", {16'h0, r_data}, 32'h0);
        chk("t6_wr_ready", {31'h0, wr_ready}, 32'h1);
        chk("t6_load_done", {31'h0, load_done}, 32'h0);
        cyc();
        reset = 1'b1;
        cyc();
        fill("t6_fresh", 200);
        rd(0, 16'd201, 1'b1);
        rd(4, 16'd205, 1'b1);
        cyc();
        cyc();
        chk("sb_drain", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
